// File: rtl/cntr_bs_router.sv
// Push-side front end of the bank scheduler: stages one transaction and steers it
// into a read or write FIFO, preferring open-row hits, else round-robin over empty FIFOs.
module cntr_bs_router #(
    parameter int RD_FIFO_NUM = 4,
    parameter int WR_FIFO_NUM = 3,
    parameter int DQ          = 16,
    parameter int IDX         = 6,
    parameter int RA          = 16,
    parameter int CA          = 10,
    parameter int STALL_W     = 8,
    localparam int FIFO_NUM   = RD_FIFO_NUM + WR_FIFO_NUM
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_type,
    input  logic [DQ-1:0]          req_dq,
    input  logic [IDX-1:0]         req_idx,
    input  logic [RA-1:0]          req_ra,
    input  logic [CA-1:0]          req_ca,
    input  logic [RA*FIFO_NUM-1:0] last_ra,
    input  logic [FIFO_NUM-1:0]    full,
    input  logic [FIFO_NUM-1:0]    empty,
    output logic [FIFO_NUM-1:0]    push,
    output logic [DQ-1:0]          dq_o,
    output logic [IDX-1:0]         idx_o,
    output logic [RA-1:0]          ra_o,
    output logic [CA-1:0]          ca_o,
    output logic [STALL_W-1:0]     stall_cnt
);

    localparam int FIFO_W = (FIFO_NUM > 1) ? $clog2(FIFO_NUM) : 1;
    localparam int RD_W   = (RD_FIFO_NUM > 1) ? $clog2(RD_FIFO_NUM) : 1;
    localparam int WR_W   = (WR_FIFO_NUM > 1) ? $clog2(WR_FIFO_NUM) : 1;

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t              state_r, state_nx_s;
    logic                type_r;
    logic [DQ-1:0]       dq_r;
    logic [IDX-1:0]      idx_r;
    logic [RA-1:0]       ra_r;
    logic [CA-1:0]       ca_r;
    logic [RD_W-1:0]     rd_rr_r, rd_rr_nx_s;
    logic [WR_W-1:0]     wr_rr_r, wr_rr_nx_s;
    logic [STALL_W-1:0]  stall_cnt_r;

    logic                hold_v_s, accept_s, placed_s;
    logic                hit_found_s, new_found_s;
    logic [FIFO_W-1:0]   hit_sel_s, new_sel_s, sel_s;
    logic [FIFO_NUM-1:0] push_s;
    int                  j_s;

    assign hold_v_s  = (state_r == HOLD);
    assign req_ready = !hold_v_s || placed_s;
    assign accept_s  = req_valid && req_ready;

    // Row-hit search: scanned downward so the lowest matching candidate wins.
    always_comb begin
        hit_found_s = 1'b0;
        hit_sel_s   = '0;
        for (int g = FIFO_NUM - 1; g >= 0; g--) begin
            if (((type_r && g < RD_FIFO_NUM) || (!type_r && g >= RD_FIFO_NUM)) &&
                !empty[g] && !full[g] && (last_ra[g*RA +: RA] == ra_r)) begin
                hit_found_s = 1'b1;
                hit_sel_s   = FIFO_W'(g);
            end else begin
                hit_sel_s   = hit_sel_s;
            end
        end
    end

    // New-row search: first empty FIFO of the group circularly from its pointer.
    always_comb begin
        new_found_s = 1'b0;
        new_sel_s   = '0;
        rd_rr_nx_s  = rd_rr_r;
        wr_rr_nx_s  = wr_rr_r;
        j_s         = 0;
        if (type_r) begin
            for (int k = RD_FIFO_NUM - 1; k >= 0; k--) begin
                j_s = (int'(rd_rr_r) + k) % RD_FIFO_NUM;
                if (empty[j_s]) begin
                    new_found_s = 1'b1;
                    new_sel_s   = FIFO_W'(j_s);
                    rd_rr_nx_s  = RD_W'((j_s + 1) % RD_FIFO_NUM);
                end else begin
                    new_sel_s   = new_sel_s;
                end
            end
        end else begin
            for (int k = WR_FIFO_NUM - 1; k >= 0; k--) begin
                j_s = (int'(wr_rr_r) + k) % WR_FIFO_NUM;
                if (empty[RD_FIFO_NUM + j_s]) begin
                    new_found_s = 1'b1;
                    new_sel_s   = FIFO_W'(RD_FIFO_NUM + j_s);
                    wr_rr_nx_s  = WR_W'((j_s + 1) % WR_FIFO_NUM);
                end else begin
                    new_sel_s   = new_sel_s;
                end
            end
        end
    end

    // Final selection and one-hot push.
    always_comb begin
        push_s   = '0;
        sel_s    = hit_found_s ? hit_sel_s : new_sel_s;
        placed_s = hold_v_s && (hit_found_s || new_found_s);
        if (placed_s) begin
            push_s[sel_s] = 1'b1;
        end else begin
            push_s = '0;
        end
    end

    // Next-state logic for the staging register occupancy.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE:    state_nx_s = accept_s ? HOLD : IDLE;
            HOLD:    state_nx_s = (placed_s && !accept_s) ? IDLE : HOLD;
            default: state_nx_s = IDLE;
        endcase
    end

    // State, staging fields, round-robin pointers and stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            type_r      <= 1'b0;
            dq_r        <= '0;
            idx_r       <= '0;
            ra_r        <= '0;
            ca_r        <= '0;
            rd_rr_r     <= '0;
            wr_rr_r     <= '0;
            stall_cnt_r <= '0;
        end else begin
            state_r <= state_nx_s;
            if (accept_s) begin
                type_r <= req_type;
                dq_r   <= req_dq;
                idx_r  <= req_idx;
                ra_r   <= req_ra;
                ca_r   <= req_ca;
            end
            // Pointers move only on new-row placements; row hits leave them alone.
            if (placed_s && !hit_found_s) begin
                rd_rr_r <= rd_rr_nx_s;
                wr_rr_r <= wr_rr_nx_s;
            end
            if ((accept_s && !hold_v_s) || placed_s) begin
                stall_cnt_r <= '0;
            end else if (hold_v_s && (stall_cnt_r != {STALL_W{1'b1}})) begin
                stall_cnt_r <= stall_cnt_r + STALL_W'(1);
            end
        end
    end

    assign push      = push_s;
    assign dq_o      = (hold_v_s && !type_r) ? dq_r : '0;
    assign idx_o     = hold_v_s ? idx_r : '0;
    assign ra_o      = hold_v_s ? ra_r : '0;
    assign ca_o      = hold_v_s ? ca_r : '0;
    assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_cntr_bs_router.sv
// Randomized and directed bench for cntr_bs_router against a transaction-level placement model.
module tb_cntr_bs_router;

    localparam int NRD = 4;
    localparam int NWR = 3;
    localparam int NF  = NRD + NWR;

    logic           clk = 1'b0;
    logic           rst, req_valid, req_ready, req_type;
    logic [15:0]    req_dq, req_ra, ra_o, dq_o;
    logic [5:0]     req_idx, idx_o;
    logic [9:0]     req_ca, ca_o;
    logic [16*NF-1:0] last_ra;
    logic [NF-1:0]  full, empty, push;
    logic [7:0]     stall_cnt;

    cntr_bs_router dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_type(req_type), .req_dq(req_dq), .req_idx(req_idx), .req_ra(req_ra),
        .req_ca(req_ca), .last_ra(last_ra), .full(full), .empty(empty), .push(push),
        .dq_o(dq_o), .idx_o(idx_o), .ra_o(ra_o), .ca_o(ca_o), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: what the staging register holds and where each group's pointer sits.
    logic        m_hold, m_type;
    logic [15:0] m_dq, m_ra;
    logic [5:0]  m_idx;
    logic [9:0]  m_ca;
    int          m_rd_rr, m_wr_rr, m_stall;

    logic [NF-1:0] obs_push;
    logic [15:0]   obs_dq;
    logic [7:0]    obs_stall;
    logic          obs_ready;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hold = 1'b0; m_type = 1'b0; m_dq = '0; m_ra = '0; m_idx = '0; m_ca = '0;
        m_rd_rr = 0; m_wr_rr = 0; m_stall = 0;
    endtask

    task automatic step(input logic r, input logic v, input logic t, input logic [15:0] dq,
                        input logic [5:0] idx, input logic [15:0] ra, input logic [9:0] ca,
                        input logic [16*NF-1:0] lra, input logic [NF-1:0] fu,
                        input logic [NF-1:0] em);
        int base, n, rr, hit, fresh, sel;
        logic placed, exp_ready, acc;
        logic [NF-1:0] exp_push;
        rst = r; req_valid = v; req_type = t; req_dq = dq; req_idx = idx;
        req_ra = ra; req_ca = ca; last_ra = lra; full = fu; empty = em;
        #1;
        base = m_type ? 0 : NRD;
        n    = m_type ? NRD : NWR;
        rr   = m_type ? m_rd_rr : m_wr_rr;
        hit = -1; fresh = -1;
        for (int i = 0; i < n; i++)
            if (hit < 0 && !em[base+i] && !fu[base+i] && lra[(base+i)*16 +: 16] == m_ra)
                hit = base + i;
        for (int k = 0; k < n; k++)
            if (fresh < 0 && em[base + (rr + k) % n]) fresh = base + (rr + k) % n;
        sel       = (hit >= 0) ? hit : fresh;
        placed    = m_hold && (sel >= 0);
        exp_push  = placed ? (NF'(1) << sel) : '0;
        exp_ready = !m_hold || placed;
        check("push", 32'(push), 32'(exp_push));
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("ra_o", 32'(ra_o), m_hold ? 32'(m_ra) : 32'd0);
        check("idx_o", 32'(idx_o), m_hold ? 32'(m_idx) : 32'd0);
        check("ca_o", 32'(ca_o), m_hold ? 32'(m_ca) : 32'd0);
        check("dq_o", 32'(dq_o), (m_hold && !m_type) ? 32'(m_dq) : 32'd0);
        check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        obs_push = push; obs_dq = dq_o; obs_stall = stall_cnt; obs_ready = req_ready;
        if (r) begin
            model_reset();
        end else begin
            acc = v && exp_ready;
            if ((acc && !m_hold) || placed) m_stall = 0;
            else if (m_hold && m_stall < 255) m_stall++;
            if (placed && hit < 0) begin
                if (m_type) m_rd_rr = (sel - base + 1) % n;
                else        m_wr_rr = (sel - base + 1) % n;
            end
            if (acc) begin
                m_hold = 1'b1; m_type = t; m_dq = dq; m_idx = idx; m_ra = ra; m_ca = ca;
            end else if (placed) begin
                m_hold = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    logic [16*NF-1:0] lra_v;
    logic [NF-1:0]    fu_v, em_v;

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_type = 1'b0; req_dq = '0; req_idx = '0;
        req_ra = '0; req_ca = '0; last_ra = '0; full = '0; empty = '1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // Reset state, then the directed placement scenarios.
        step(1'b0, 1'b0, 1'b0, 16'h0, 6'd0, 16'h0, 10'h0, '0, '0, 7'h7F);
        check("rst_ready", 32'(obs_ready), 32'd1);
        step(1'b0, 1'b1, 1'b1, 16'h0, 6'd5, 16'h0012, 10'h001, '0, '0, 7'h7F);
        step(1'b0, 1'b1, 1'b1, 16'h0, 6'd6, 16'h0012, 10'h002, '0, '0, 7'h7F);
        check("tp1_push", 32'(obs_push), 32'h01);
        lra_v = '0; lra_v[15:0] = 16'h0012;
        step(1'b0, 1'b1, 1'b1, 16'h0, 6'd7, 16'h0034, 10'h003, lra_v, '0, 7'h7E);
        check("tp2_hit", 32'(obs_push), 32'h01);
        step(1'b0, 1'b1, 1'b0, 16'hBEEF, 6'd8, 16'h0100, 10'h004, lra_v, '0, 7'h7E);
        check("tp3_push", 32'(obs_push), 32'h02);
        for (int c = 0; c < 4; c++) begin
            step(1'b0, 1'b1, 1'b1, 16'h0, 6'd9, 16'h0012, 10'h005, '0, '0, 7'h0F);
            check("tp4_stall", 32'(obs_stall), 32'(c));
        end
        check("tp4_not_ready", 32'(obs_ready), 32'd0);
        step(1'b0, 1'b1, 1'b1, 16'h0, 6'd9, 16'h0012, 10'h005, '0, '0, 7'h2F);
        check("tp4_push", 32'(obs_push), 32'h20);
        check("tp4_dq", 32'(obs_dq), 32'hBEEF);
        step(1'b0, 1'b1, 1'b0, 16'h1234, 6'd10, 16'h0200, 10'h006, lra_v, 7'h01, 7'h04);
        check("tp4_stall_clr", 32'(obs_stall), 32'd0);
        check("tp5_fallback", 32'(obs_push), 32'h04);
        step(1'b0, 1'b0, 1'b0, 16'h0, 6'd0, 16'h0, 10'h0, '0, '0, 7'h00);
        step(1'b1, 1'b0, 1'b0, 16'h0, 6'd0, 16'h0, 10'h0, '0, '0, 7'h00);
        step(1'b0, 1'b0, 1'b0, 16'h0, 6'd0, 16'h0, 10'h0, '0, '0, 7'h7F);
        check("tp6_push", 32'(obs_push), 32'h00);
        check("tp6_ready", 32'(obs_ready), 32'd1);
        check("tp6_stall", 32'(obs_stall), 32'd0);

        // Random traffic with a small row alphabet so hits, misses and stalls all occur.
        for (int c = 0; c < 3000; c++) begin
            for (int g = 0; g < NF; g++) begin
                lra_v[g*16 +: 16] = 16'h0010 + 16'($urandom_range(0, 3));
                fu_v[g] = ($urandom_range(0, 9) < 2);
                em_v[g] = ($urandom_range(0, 9) < 3);
            end
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) < 7), 1'($urandom),
                 16'($urandom), 6'($urandom), 16'h0010 + 16'($urandom_range(0, 3)),
                 10'($urandom), lra_v, fu_v, em_v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cntr_bs_router.md
Name: cntr_bs_router

Overview:
- Push-side front end of the bank scheduler. It accepts one transaction per cycle from the txn controller over a valid/ready handshake and holds it in a one-entry staging register.
- It chooses the target scheduler FIFO from request type, per-FIFO last row address, full flags and empty flags. It then drives a one-hot push and the transaction fields into the bank scheduler datapath.
- Placement groups same-row requests into one FIFO to maximise row hits. New rows are spread round-robin across empty FIFOs.

Parameters:
- RD_FIFO_NUM, 4, number of read FIFOs (indices 0..RD_FIFO_NUM-1)
- WR_FIFO_NUM, 3, number of write FIFOs (indices RD_FIFO_NUM..FIFO_NUM-1)
- DQ, 16, data width
- IDX, 6, transaction index width
- RA, 16, row address width
- CA, 10, column address width
- STALL_W, 8, width of saturating stall counter
- Derived: FIFO_NUM = RD_FIFO_NUM + WR_FIFO_NUM

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  request valid from txn controller
- req_ready  out  1  staging register can accept
- req_type  in  1  1 = read, 0 = write
- req_dq  in  DQ  write data
- req_idx  in  IDX  transaction index
- req_ra  in  RA  row address
- req_ca  in  CA  column address
- last_ra  in  RA*FIFO_NUM  last pushed row of each FIFO; FIFO g occupies bits [g*RA +: RA]
- full  in  FIFO_NUM  FIFO full flags
- empty  in  FIFO_NUM  FIFO empty flags
- push  out  FIFO_NUM  one-hot push to datapath (all-zero = no push)
- dq_o  out  DQ  data to datapath (0 for reads)
- idx_o  out  IDX  index to datapath
- ra_o  out  RA  row address to datapath
- ca_o  out  CA  column address to datapath
- stall_cnt  out  STALL_W  cycles a held request waited, saturating

Behaviour:
- Staging register: hold_v plus the stored type, dq, idx, ra and ca.
- Accept when req_valid & req_ready.
- req_ready = !hold_v | placed (combinational; allows back-to-back throughput of 1 per cycle).
- Latency: a request accepted at edge N is pushed in cycle N+1 at the earliest.
- Candidate set: read FIFOs if the held type is read, write FIFOs otherwise. Reads never enter write FIFOs and vice versa.
- Placement priority, evaluated combinationally each cycle while hold_v:
  - P1 row hit: the lowest-index candidate g with !empty[g] & !full[g] & last_ra[g] == held ra.
  - P2 new row: the first candidate with empty[g], searching circularly from that type's round-robin pointer.
  - Otherwise not placed: push = 0 and the request is held.
- A hit on a full FIFO is not a hit; selection falls through to P2.
- An empty FIFO's last_ra is ignored.
- placed = hold_v & (P1 | P2 found). push = one-hot of the selected FIFO when placed, else all-zero. push is never multi-hot and never asserted when !hold_v.
- Data outputs:
  - ra_o, ca_o and idx_o equal the staging register fields.
  - dq_o = held dq for writes, 0 for reads.
  - All data outputs are 0 while !hold_v.
- Round-robin pointers rd_rr in [0, RD_FIFO_NUM-1] and wr_rr in [0, WR_FIFO_NUM-1], both relative to their group.
  - Updated only on a P2 placement: pointer = (selected relative index + 1) mod group size.
  - A P1 placement leaves the pointer unchanged.
- FIFO flags and last_ra are taken to update at the edge after a push. A same-row request in the next cycle therefore sees the FIFO non-empty with a matching last_ra and takes P1.
- stall_cnt:
  - Cleared to 0 on any accept into an empty staging register, and on every placement.
  - Incremented by 1 each cycle that hold_v & !placed.
  - Saturates at all-ones.
- State machine, two states:
  - IDLE (hold_v = 0): go to HOLD on accept.
  - HOLD (hold_v = 1): stay in HOLD if placed and accept occur in the same cycle (new request loaded) or if not placed; go to IDLE if placed and no accept.
- Reset, rst = 1 at an edge:
  - hold_v = 0, state IDLE.
  - rd_rr = 0, wr_rr = 0.
  - stall_cnt = 0.
  - Staging fields = 0, so push = 0 and all data outputs = 0.
  - req_ready = 1 in the first cycle after reset.
  - A request held mid-stall is discarded, not pushed.

Test Plan:
1. After reset, all FIFOs empty; read with ra=0x0012, idx=5 accepted at edge N -> cycle N+1: push=7'b0000001, ra_o=0x0012, idx_o=5, dq_o=0; rd_rr becomes 1.
2. Next cycle, read ra=0x0012 with empty[0]=0, full[0]=0, last_ra[0]=0x0012 -> push=7'b0000001 (P1); rd_rr stays 1.
3. Read ra=0x0034 with FIFO0 holding row 0x0012 and FIFOs 1-3 empty -> push=7'b0000010; rd_rr=2.
4. Write dq=0xBEEF, ra=0x0100 with FIFOs 4-6 non-empty, last_ra not matching -> push=0, req_ready=0, stall_cnt counts 1, 2, 3. Raising empty[5]=1 -> push=7'b0100000, dq_o=0xBEEF, stall_cnt back to 0.
5. Read ra=0x0012 where FIFO0 matches but full[0]=1 and FIFO2 is empty -> push=7'b0000100 (P2 fallback, not FIFO0).
6. rst pulsed while a write is stalled in HOLD -> next cycle push=0, req_ready=1, stall_cnt=0; the held write is never pushed.
